// File: rtl/issue_queue_pkg.sv
// Shared control types for the issue stage: uop encodings, the queued item record,
// the 32-bit register mask and the default queue depth.
package issue_queue_pkg;

  localparam int unsigned IQ_DEPTH = 4;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [NUM_REGS-1:0] reg_mask_t;

  typedef enum logic [3:0] {
    UOPC_NOP, UOPC_ADD, UOPC_ADDI, UOPC_SUB, UOPC_AND, UOPC_OR, UOPC_XOR,
    UOPC_LW, UOPC_SW, UOPC_BEQ, UOPC_JAL, UOPC_LUI
  } uopc_e;

  typedef enum logic [1:0] {
    EXUT_ALU, EXUT_MEM, EXUT_BRU, EXUT_MUL
  } exut_e;

  typedef enum logic [2:0] {
    IMMT_NONE, IMMT_I, IMMT_S, IMMT_B, IMMT_U, IMMT_J
  } immt_e;

  typedef struct packed {
    uopc_e       uopcode;
    exut_e       exu_type;
    logic        has_rd;
    logic        has_rs1;
    logic        has_rs2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    immt_e       imm_type;
    logic [19:0] packed_imm;
    logic        taken;
    logic        shadowed;
  } queue_item_t;

  function automatic reg_mask_t reg_onehot(input logic [4:0] r);
    reg_onehot = reg_mask_t'(1) << r;
  endfunction

endpackage

// File: rtl/issue_queue_scoreboard.sv
// Pending-write scoreboard with same-cycle writeback bypass on the effective view.
// Latency: set/clear visible on busy_o next cycle; never stalls, updates every cycle.
module issue_queue_scoreboard
  import issue_queue_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_vld_i,
  input  logic [4:0]  set_rd_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  output logic [31:0] busy_o,
  output logic [31:0] busy_eff_o
);

  reg_mask_t busy_q, busy_d;

  // Clear applied before set so an issue and a writeback to the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d = busy_d & ~reg_onehot(wb_rd_i);
    if (set_vld_i)  busy_d = busy_d | reg_onehot(set_rd_i);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign busy_eff_o = wb_valid_i ? (busy_q & ~reg_onehot(wb_rd_i)) : busy_q;

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: circular FIFO whose head issues only when its registers are not pending.
// Latency: enqueue to issue-eligible is one cycle; enq_ready_o drops at full, head stalls on deq_ready_i or hazards.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enq_valid_i,
  output logic                   enq_ready_o,
  input  queue_item_t            enq_item_i,
  output logic                   deq_valid_o,
  input  logic                   deq_ready_i,
  output queue_item_t            deq_item_o,
  input  logic                   wb_valid_i,
  input  logic [4:0]             wb_rd_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  queue_item_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq_fire, deq_fire, head_ready;
  queue_item_t   head_item;
  logic [31:0]   busy_eff;

  assign head_item   = mem_q[head_q];
  assign enq_ready_o = count_q < CW'(DEPTH);

  assign head_ready = (!head_item.has_rs1 || !busy_eff[head_item.rs1]) &&
                      (!head_item.has_rs2 || !busy_eff[head_item.rs2]) &&
                      (!head_item.has_rd  || !busy_eff[head_item.rd]);
  assign deq_valid_o = (count_q != '0) && head_ready;

  // A flush squashes both same-cycle transfers, including the scoreboard set.
  assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
  assign deq_fire = deq_valid_o && deq_ready_i && !flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PW'(1);
      if (deq_fire) head_d = head_q + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) mem_q[tail_q] <= enq_item_i;
  end

  issue_queue_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_vld_i  (deq_fire && head_item.has_rd),
    .set_rd_i   (head_item.rd),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .busy_o     (busy_o),
    .busy_eff_o (busy_eff)
  );

  assign deq_item_o = head_item;
  assign count_o    = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, enq_valid, enq_ready, deq_valid, deq_ready, wb_valid, flush;
  queue_item_t enq_item, deq_item;
  logic [4:0]  wb_rd;
  logic [2:0]  count;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  queue_item_t qm[$];
  logic [31:0] busy_m = '0;
  logic        exp_dv;
  bit          model_on = 1'b0;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_item_i(enq_item),
    .deq_valid_o(deq_valid), .deq_ready_i(deq_ready), .deq_item_o(deq_item),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush),
    .count_o(count), .busy_o(busy)
  );

  typedef struct {
    logic       ev;
    logic       hrd;
    logic [4:0] rd;
    logic       hrs1;
    logic [4:0] rs1;
    logic       dr;
    logic       wv;
    logic [4:0] wr;
    logic [2:0] e_cnt;
    logic       e_dv;
    logic       e_er;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mkv(int ev, int hrd, int rd, int hrs1, int rs1, int dr,
                               int wv, int wr, int cnt, int dv, int er);
    vec_t r;
    r.ev = (ev != 0); r.hrd = (hrd != 0); r.rd = 5'(rd); r.hrs1 = (hrs1 != 0);
    r.rs1 = 5'(rs1); r.dr = (dr != 0); r.wv = (wv != 0); r.wr = 5'(wr);
    r.e_cnt = 3'(cnt); r.e_dv = (dv != 0); r.e_er = (er != 0);
    return r;
  endfunction

  function automatic queue_item_t mk_item(int hrd, int rd, int hrs1, int rs1,
                                          int hrs2, int rs2, int tag);
    queue_item_t it;
    it = '0;
    it.uopcode = UOPC_ADD; it.exu_type = EXUT_ALU; it.imm_type = IMMT_NONE;
    it.has_rd = (hrd != 0); it.rd = 5'(rd);
    it.has_rs1 = (hrs1 != 0); it.rs1 = 5'(rs1);
    it.has_rs2 = (hrs2 != 0); it.rs2 = 5'(rs2);
    it.packed_imm = 20'(tag);
    return it;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: queue contents and pending-register set, evaluated from the current inputs.
  task automatic model_check(input string tag);
    logic [31:0] beff;
    queue_item_t h;
    beff = busy_m;
    if (wb_valid) beff[wb_rd] = 1'b0;
    exp_dv = 1'b0;
    if (qm.size() > 0) begin
      h = qm[0];
      exp_dv = (!h.has_rs1 || !beff[h.rs1]) && (!h.has_rs2 || !beff[h.rs2]) &&
               (!h.has_rd || !beff[h.rd]);
    end
    if (model_on) begin
      chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(qm.size() < DEPTH));
      chk({tag, ".deq_valid"}, 64'(deq_valid), 64'(exp_dv));
      chk({tag, ".count"}, 64'(count), 64'(qm.size()));
      chk({tag, ".busy"}, 64'(busy), 64'(busy_m));
      if (qm.size() > 0) chk({tag, ".deq_item"}, 64'(deq_item), 64'(qm[0]));
    end
  endtask

  task automatic model_update();
    queue_item_t h;
    logic deqf, enqf;
    h = '0;
    deqf = deq_ready && exp_dv;
    enqf = enq_valid && (qm.size() < DEPTH);
    if (rst) begin
      qm.delete();
      busy_m = '0;
      model_on = 1'b1;
    end else begin
      if (flush) qm.delete();
      else begin
        if (deqf) h = qm.pop_front();
        if (enqf) qm.push_back(enq_item);
      end
      if (wb_valid && wb_rd != 5'd0) busy_m[wb_rd] = 1'b0;
      if (!flush && deqf && h.has_rd && h.rd != 5'd0) busy_m[h.rd] = 1'b1;
    end
  endtask

  task automatic drive(input string tag, input logic ev, input queue_item_t it, input logic dr,
                       input logic wv, input logic [4:0] wr, input logic fl, input logic rs);
    enq_valid = ev; enq_item = it; deq_ready = dr;
    wb_valid = wv; wb_rd = wr; flush = fl; rst = rs;
    #1;
    model_check(tag);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic ev, input queue_item_t it, input logic dr,
                      input logic wv, input logic [4:0] wr, input logic fl, input logic rs);
    drive(tag, ev, it, dr, wv, wr, fl, rs);
    tick();
  endtask

  queue_item_t nil;

  initial begin
    nil = '0;
    // Fill, 5th rejected, drain; then the RAW stall with a same-cycle writeback release.
    tbl[0]  = mkv(1,0,0,0,0, 0,0,0, 0,0,1);
    tbl[1]  = mkv(1,0,0,0,0, 0,0,0, 1,1,1);
    tbl[2]  = mkv(1,0,0,0,0, 0,0,0, 2,1,1);
    tbl[3]  = mkv(1,0,0,0,0, 0,0,0, 3,1,1);
    tbl[4]  = mkv(1,0,0,0,0, 0,0,0, 4,1,0);
    tbl[5]  = mkv(0,0,0,0,0, 0,0,0, 4,1,0);
    tbl[6]  = mkv(0,0,0,0,0, 1,0,0, 4,1,0);
    tbl[7]  = mkv(0,0,0,0,0, 1,0,0, 3,1,1);
    tbl[8]  = mkv(0,0,0,0,0, 1,0,0, 2,1,1);
    tbl[9]  = mkv(0,0,0,0,0, 1,0,0, 1,1,1);
    tbl[10] = mkv(1,1,5,0,0, 0,0,0, 0,0,1);
    tbl[11] = mkv(1,1,6,1,5, 1,0,0, 1,1,1);
    tbl[12] = mkv(0,0,0,0,0, 1,0,0, 1,0,1);
    tbl[13] = mkv(0,0,0,0,0, 1,0,0, 1,0,1);
    tbl[14] = mkv(0,0,0,0,0, 1,1,5, 1,1,1);
    tbl[15] = mkv(0,0,0,0,0, 0,0,0, 0,0,1);
    tbl[16] = mkv(0,0,0,0,0, 0,1,6, 0,0,1);

    step("rst0", 1'b0, nil, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("rst1", 1'b0, nil, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive("reset", 1'b0, nil, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.enq_ready", 64'(enq_ready), 64'd1);
    chk("reset.deq_valid", 64'(deq_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    tick();

    for (int i = 0; i < 17; i++) begin
      drive($sformatf("vec%0d", i), tbl[i].ev,
            mk_item(int'(tbl[i].hrd), int'(tbl[i].rd), int'(tbl[i].hrs1), int'(tbl[i].rs1), 0, 0, i),
            tbl[i].dr, tbl[i].wv, tbl[i].wr, 1'b0, 1'b0);
      chk($sformatf("vec%0d.tbl_count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.tbl_deq_valid", i), 64'(deq_valid), 64'(tbl[i].e_dv));
      chk($sformatf("vec%0d.tbl_enq_ready", i), 64'(enq_ready), 64'(tbl[i].e_er));
      tick();
    end

    // Issue of rd=7 coinciding with a writeback of x7: the new pending write wins.
    step("sw.enq", 1'b1, mk_item(1,7,0,0,0,0,50), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("sw.iss", 1'b0, nil, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    chk("setwins.busy7", 64'(busy[7]), 64'd1);
    step("x0.enq", 1'b1, mk_item(1,0,0,0,0,0,51), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("x0.iss", 1'b0, nil, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("x0.busy", 64'(busy), 64'h80);
    step("sw.clr", 1'b0, nil, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);

    step("wrap.pre", 1'b1, mk_item(0,0,0,0,0,0,100), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("wrap%0d", i), 1'b1, mk_item(0,0,0,0,0,0,101+i), 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      chk($sformatf("wrap%0d.count_le_depth", i), 64'(count <= 3'(DEPTH)), 64'd1);
    end
    step("wrap.drain", 1'b0, nil, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

    step("fl.enq3", 1'b1, mk_item(1,3,0,0,0,0,200), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("fl.iss3", 1'b0, nil, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("fl.fill", 1'b1, mk_item(1,9,0,0,0,0,201+i), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive("fl.flush", 1'b1, mk_item(0,0,0,0,0,0,210), 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("flush.count_before", 64'(count), 64'd3);
    tick();
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.deq_valid", 64'(deq_valid), 64'd0);
    chk("flush.busy", 64'(busy), 64'h8);

    step("rs.enqA", 1'b1, mk_item(0,0,0,0,0,0,300), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("rs.enqB", 1'b1, mk_item(0,0,0,0,0,0,301), 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive("rs.assert", 1'b1, mk_item(1,4,0,0,0,0,302), 1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
    chk("midrst.count_before", 64'(count), 64'd2);
    tick();
    drive("rs.after", 1'b0, nil, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("midrst.count", 64'(count), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.enq_ready", 64'(enq_ready), 64'd1);
    chk("midrst.deq_valid", 64'(deq_valid), 64'd0);
    tick();

    for (int i = 0; i < 400; i++) begin
      queue_item_t it;
      it = mk_item(int'($urandom_range(0,1)), int'($urandom_range(0,7)),
                   int'($urandom_range(0,1)), int'($urandom_range(0,7)),
                   int'($urandom_range(0,1)), int'($urandom_range(0,7)), 1000+i);
      step($sformatf("rnd%0d", i), $urandom_range(0,3) != 0, it, $urandom_range(0,1) != 0,
           $urandom_range(0,2) == 0, 5'($urandom_range(0,7)),
           $urandom_range(0,40) == 0, $urandom_range(0,150) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
